bram_filter_frame_sequencer: RTL
================================

# bram_filter_frame_sequencer

Frame-level controller placed in front of `bram_filter_system`. It admits exactly one decimated frame of disparity/confidence words and one frame of downsampled gray pixels into the filter, then holds both input streams until the filter has emitted the matching frame of output. It reports frame completion and counts frames. This guarantees the filter's BRAM line buffers never see data from two frames at once.

## Interface
Parameters:
- `dec_frame_w`, 120, decimated frame width in pixels
- `dec_frame_h`, 240, decimated frame height in pixels
- `disp_conf_w`, 16, disparity/confidence word width
- `gray_w`, 8, gray pixel width

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  single-cycle request to begin a frame; honoured only in IDLE or DONE
- `continuous`  in  1  when 1, DONE chains directly into the next frame
- `disp_conf_up_data`  in  `disp_conf_w`  upstream disparity/confidence word
- `disp_conf_up_valid`  in  1
- `disp_conf_up_ready`  out  1
- `disp_conf_dn_data`  out  `disp_conf_w`  to filter
- `disp_conf_dn_valid`  out  1
- `disp_conf_dn_ready`  in  1
- `gray_up_data`  in  `gray_w`
- `gray_up_valid`  in  1
- `gray_up_ready`  out  1
- `gray_dn_data`  out  `gray_w`  to filter
- `gray_dn_valid`  out  1
- `gray_dn_ready`  in  1
- `filt_out_valid`  in  1  filter output monitor
- `filt_out_ready`  in  1  filter output sink ready
- `busy`  out  1  high in RUN and DRAIN
- `frame_done`  out  1  one-cycle pulse per completed frame
- `frame_count`  out  16  completed frames, wraps at 2^16
- `out_err`  out  1  sticky flag: output beat seen outside RUN/DRAIN

## Operation
- Define N = `dec_frame_w*dec_frame_h`. Counter width is `$clog2(N+1)`.
- Three beat counters:
  - `dc_cnt` increments on `disp_conf_dn_valid & disp_conf_dn_ready`.
  - `gr_cnt` increments on `gray_dn_valid & gray_dn_ready`.
  - `out_cnt` increments on `filt_out_valid & filt_out_ready`.
  - All three clear when a frame is entered.
- Gating is combinational; data passes straight through.
  - `x_dn_valid = x_up_valid & (state==RUN) & (x_cnt<N)`
  - `x_up_ready = x_dn_ready & (state==RUN) & (x_cnt<N)`
  - The two streams are gated independently and may finish in either order.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`, or on `continuous` = 1.
  - RUN → DRAIN when both input counts equal N (counting the current beat) and `out_cnt` < N after the current beat.
  - RUN → DONE directly if all three counts reach N in the same cycle.
  - DRAIN → DONE when `out_cnt` reaches N, counting the current beat.
  - DONE lasts one cycle: `frame_done` = 1 and `frame_count` increments. Next state is RUN if `continuous | start`, otherwise IDLE.
- `out_cnt` saturates at N.
- An output beat in IDLE or DONE sets `out_err`. `out_err` clears only on reset.
- `start` in RUN or DRAIN is ignored; it is not queued.

## Timing
- Reset values:
  - state = IDLE
  - all counters = 0
  - `frame_count` = 0
  - `busy`, `frame_done`, `out_err` = 0
  - all `*_dn_valid` and `*_up_ready` = 0
- Zero-cycle latency from upstream to downstream; no data registers.
- `busy` and `frame_done` are registered, derived from state.
- The first beat can be accepted in the cycle after `start` is sampled.
- In continuous mode there is exactly one non-admitting cycle (DONE) between frames.
- Asserting reset mid-frame returns asynchronously to IDLE. Partial-frame counts are discarded and `frame_count` is not incremented.

## Structure
- Package `bram_filter_seq_pkg` holds:
  - the `seq_state_t` enum (IDLE, RUN, DRAIN, DONE)
  - `function pix_count(w,h)`
  - the counter-width localparam helper
- One sub-module, `frame_beat_counter`:
  - parameter N
  - inputs: clear, beat
  - outputs: `count`, `at_limit`, `will_hit` (count+beat==N)
  - instantiated three times

## Test plan
All scenarios use `dec_frame_w`=4, `dec_frame_h`=2, so N=8.
1. Reset, then pulse `start`; stream 8 words on each input, with the filter sink always ready and echoing 8 output beats after a delay. Expect:
   - `busy` rises in the cycle after `start`
   - `frame_done` pulses once
   - `frame_count` = 1
   - return to IDLE
2. Offer 12 gray pixels while disparity is stalled. Expect:
   - only 8 gray pixels pass
   - `gray_up_ready` = 0 from the 9th pixel on
   - state stays RUN until the 8th disparity word, then DRAIN
3. Hold `disp_conf_dn_ready` and `gray_dn_ready` toggling at 50% and `filt_out_ready` at 33%. Expect:
   - counts exact
   - no beat is dropped or duplicated (scoreboard the data order)
4. Hold `continuous` = 1 for 3 frames. Expect:
   - `frame_count` = 3
   - exactly one gap cycle between frames
   - no input accepted during DRAIN
5. Drive `filt_out_valid` = 1 while IDLE. Expect `out_err` = 1, staying high until reset.
6. Assert reset after 5 input beats in RUN. Expect:
   - immediate IDLE with all outputs 0
   - after a new `start`, a full 8-beat frame completes normally

Source files
------------

// File: rtl/bram_filter_frame_sequencer_pkg.sv
// Shared types and helpers for the frame sequencer in front of bram_filter_system.
// Contents:
//   seq_state_t  - sequencer states (IDLE, RUN, DRAIN, DONE)
//   pix_count    - pixels in one decimated frame
//   cnt_width    - bits needed to hold a beat count from 0 up to and including N
package bram_filter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int unsigned FRAME_COUNT_W = 16;

    function automatic int unsigned pix_count(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bram_filter_frame_sequencer_beat_counter.sv
// Per-stream beat counter, saturating at N.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - synchronous clear on frame entry (wins over beat)
//   beat        - one handshake completed this cycle
//   count       - beats seen this frame (0..N)
//   at_limit    - count == N
//   will_hit    - count + beat == N (limit reached including the current beat)
module frame_beat_counter
    import bram_filter_seq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      beat,
    output logic [cnt_width(N)-1:0]   count,
    output logic                      at_limit,
    output logic                      will_hit
);

    localparam int unsigned W = cnt_width(N);

    logic [W:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (beat && !at_limit) begin
            count <= count + 1'b1;
        end
    end

    // One extra bit so count+beat never wraps before the compare.
    assign sum      = {1'b0, count} + {{W{1'b0}}, beat};
    assign at_limit = (count == W'(N));
    assign will_hit = (sum == (W + 1)'(N));

endmodule

// File: rtl/bram_filter_frame_sequencer.sv
// Frame-level admission controller for bram_filter_system. Admits exactly one
// decimated frame on each input stream, then holds both streams until the
// filter has emitted a full frame of output beats.
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   start, continuous         - frame request / chain frames back to back
//   disp_conf_up_* / _dn_*    - disparity/confidence stream, gated pass-through
//   gray_up_* / gray_dn_*     - gray pixel stream, gated pass-through
//   filt_out_valid/_ready     - filter output handshake monitor
//   busy                      - high in RUN and DRAIN
//   frame_done                - one-cycle pulse per completed frame
//   frame_count               - completed frames, wraps at 2^16
//   out_err                   - sticky: output beat seen outside RUN/DRAIN
module bram_filter_frame_sequencer
    import bram_filter_seq_pkg::*;
#(
    parameter int unsigned dec_frame_w = 120,
    parameter int unsigned dec_frame_h = 240,
    parameter int unsigned disp_conf_w = 16,
    parameter int unsigned gray_w      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      continuous,
    input  logic [disp_conf_w-1:0]    disp_conf_up_data,
    input  logic                      disp_conf_up_valid,
    output logic                      disp_conf_up_ready,
    output logic [disp_conf_w-1:0]    disp_conf_dn_data,
    output logic                      disp_conf_dn_valid,
    input  logic                      disp_conf_dn_ready,
    input  logic [gray_w-1:0]         gray_up_data,
    input  logic                      gray_up_valid,
    output logic                      gray_up_ready,
    output logic [gray_w-1:0]         gray_dn_data,
    output logic                      gray_dn_valid,
    input  logic                      gray_dn_ready,
    input  logic                      filt_out_valid,
    input  logic                      filt_out_ready,
    output logic                      busy,
    output logic                      frame_done,
    output logic [FRAME_COUNT_W-1:0]  frame_count,
    output logic                      out_err
);

    localparam int unsigned N  = pix_count(dec_frame_w, dec_frame_h);
    localparam int unsigned CW = cnt_width(N);

    seq_state_t state, next_state;

    logic          run;
    logic          clear;
    logic          dc_beat, gr_beat, out_beat;
    logic [CW-1:0] dc_cnt, gr_cnt, out_cnt;
    logic          dc_lim, gr_lim, out_lim;
    logic          dc_hit, gr_hit, out_hit;
    logic          out_reached;
    logic          unused_counts;

    assign run = (state == RUN);

    // Straight pass-through; only the handshake is gated.
    assign disp_conf_dn_data  = disp_conf_up_data;
    assign disp_conf_dn_valid = disp_conf_up_valid & run & ~dc_lim;
    assign disp_conf_up_ready = disp_conf_dn_ready & run & ~dc_lim;

    assign gray_dn_data  = gray_up_data;
    assign gray_dn_valid = gray_up_valid & run & ~gr_lim;
    assign gray_up_ready = gray_dn_ready & run & ~gr_lim;

    assign dc_beat  = disp_conf_dn_valid & disp_conf_dn_ready;
    assign gr_beat  = gray_dn_valid & gray_dn_ready;
    assign out_beat = filt_out_valid & filt_out_ready;

    // Output counter saturates, so a beat while already at N must still
    // read as "reached" even though count+beat overshoots.
    assign out_reached = out_lim | out_hit;

    // Only the limit flags steer the FSM; raw counts are kept for visibility.
    assign unused_counts = ^{dc_cnt, gr_cnt, out_cnt};

    frame_beat_counter #(.N(N)) u_dc_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .beat     (dc_beat),
        .count    (dc_cnt),
        .at_limit (dc_lim),
        .will_hit (dc_hit)
    );

    frame_beat_counter #(.N(N)) u_gr_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .beat     (gr_beat),
        .count    (gr_cnt),
        .at_limit (gr_lim),
        .will_hit (gr_hit)
    );

    frame_beat_counter #(.N(N)) u_out_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .beat     (out_beat),
        .count    (out_cnt),
        .at_limit (out_lim),
        .will_hit (out_hit)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start || continuous) next_state = RUN;
            RUN:     if (dc_hit && gr_hit) next_state = out_reached ? DONE : DRAIN;
            DRAIN:   if (out_reached) next_state = DONE;
            DONE:    next_state = (continuous || start) ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counters restart whenever a frame is entered (from IDLE or DONE).
    assign clear = (next_state == RUN) && (state != RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            out_err     <= 1'b0;
        end else begin
            state      <= next_state;
            busy       <= (next_state == RUN) || (next_state == DRAIN);
            frame_done <= (next_state == DONE);
            if (next_state == DONE) begin
                frame_count <= frame_count + 1'b1;
            end
            if (out_beat && (state == IDLE || state == DONE)) begin
                out_err <= 1'b1;
            end
        end
    end

endmodule
